proj_hasher: RTL and testbench

- Streaming hash stage, directly upstream of proj_sorter.
- Accepts one data word per cycle (valid/last framing), tags each accepted word with a running index, and computes a 3-stage pipelined multiplicative/xorshift hash.
- Drives signature, index and end_sorting into the sorter every cycle.
- Idle cycles carry a max-value sentinel signature so the sorter's bottom-k set is never disturbed.

---
 rtl/proj_pkg.sv | 32 +++
 rtl/proj_hash_mix.sv | 50 +++++
 rtl/proj_hasher.sv | 178 +++++++++++++++++
 tb/tb_proj_hasher.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/proj_pkg.sv
// -----------------------------------------------------------------------------
// proj_pkg
// Shared constants and types for the proj_* streaming blocks (hasher -> sorter).
// Holds the hasher/sorter interface widths, the hasher multiplier and seed
// defaults, the idle sentinel signature and the hasher pipeline stage record.
// No ports (package).
// -----------------------------------------------------------------------------
package proj_pkg;

    // Widths shared between proj_hasher and proj_sorter.
    localparam int HASHER_SORTER_SIGNATURE = 32;
    localparam int INDICE_LEN              = 8;
    localparam int HASHER_DATA_LEN         = 32;

    // Golden-ratio odd multiplier and default xor seed for the hash.
    localparam logic [HASHER_SORTER_SIGNATURE-1:0] HASHER_MULT = 32'h9E37_79B1;
    localparam logic [HASHER_SORTER_SIGNATURE-1:0] HASHER_SEED = '0;

    // All-ones is never a real signature; idle slots carry it so the sorter's
    // bottom-k set is left untouched.
    localparam logic [HASHER_SORTER_SIGNATURE-1:0] HASHER_SENTINEL = '1;

    // One hasher pipeline slot: control flags plus the item's index and the
    // partially computed hash value.
    typedef struct packed {
        logic                               valid;
        logic                               last;
        logic [INDICE_LEN-1:0]              index;
        logic [HASHER_SORTER_SIGNATURE-1:0] value;
    } hasher_stage_t;

endpackage : proj_pkg

// File: rtl/proj_hash_mix.sv
// -----------------------------------------------------------------------------
// proj_hash_mix
// Purely combinational hash arithmetic used by proj_hasher. The two halves are
// exposed separately so the owner can put a register between them.
//   mul_a_i  [SIGNATURE_LEN] : seeded word (stage-1 value)
//   mul_o    [SIGNATURE_LEN] : (mul_a_i * MULT) mod 2^SIGNATURE_LEN
//   mix_b_i  [SIGNATURE_LEN] : product (stage-2 value)
//   mix_o    [SIGNATURE_LEN] : b ^ (b >> SIGNATURE_LEN/2), clamped below all-ones
// -----------------------------------------------------------------------------
module proj_hash_mix
    import proj_pkg::*;
#(
    parameter int                       SIGNATURE_LEN = HASHER_SORTER_SIGNATURE,
    parameter logic [SIGNATURE_LEN-1:0] MULT          = HASHER_MULT
) (
    input  logic [SIGNATURE_LEN-1:0] mul_a_i,
    output logic [SIGNATURE_LEN-1:0] mul_o,
    input  logic [SIGNATURE_LEN-1:0] mix_b_i,
    output logic [SIGNATURE_LEN-1:0] mix_o
);

    localparam logic [SIGNATURE_LEN-1:0] ALL_ONES   = '1;
    localparam logic [SIGNATURE_LEN-1:0] CLAMP_MAX  = ALL_ONES - 1'b1;

    // Low half of the full product only; the sized target drops the high bits.
    function automatic logic [SIGNATURE_LEN-1:0] mult_low(
        input logic [SIGNATURE_LEN-1:0] a
    );
        logic [SIGNATURE_LEN-1:0] p;
        p = a * MULT;
        return p;
    endfunction

    // Fold the high half into the low half, then keep all-ones free for the
    // idle sentinel by mapping a genuine all-ones result one step down.
    function automatic logic [SIGNATURE_LEN-1:0] xorshift_clamp(
        input logic [SIGNATURE_LEN-1:0] b
    );
        logic [SIGNATURE_LEN-1:0] c;
        c = b ^ (b >> (SIGNATURE_LEN / 2));
        if (c == ALL_ONES) begin
            c = CLAMP_MAX;
        end
        return c;
    endfunction

    assign mul_o = mult_low(mul_a_i);
    assign mix_o = xorshift_clamp(mix_b_i);

endmodule : proj_hash_mix

// File: rtl/proj_hasher.sv
// -----------------------------------------------------------------------------
// proj_hasher
// Streaming hash stage feeding proj_sorter. Every in_valid word is accepted
// (no backpressure), tagged with a running index that restarts after in_last,
// and hashed through a seed-xor / multiply / xorshift pipeline. Results leave
// a registered output stage three edges after acceptance; idle slots present
// the all-ones sentinel signature.
//
// Ports:
//   in_clk         clock
//   in_rst_n       synchronous active-low reset
//   in_data        [DATA_LEN]      data word
//   in_valid       in_data valid this cycle
//   in_last        final word of the set (qualified by in_valid)
//   in_seed        [SIGNATURE_LEN] new seed        (PROJ_HASHER_SEED_LOAD_EN only)
//   in_seed_load   load in_seed into the seed reg  (PROJ_HASHER_SEED_LOAD_EN only)
//   out_signature  [SIGNATURE_LEN] hash or sentinel, to sorter in_signature
//   out_index      [INDICE_LEN]    item index, to sorter in_index
//   out_valid      out_signature/out_index hold a real item
//   out_end        one-cycle pulse with the last item, to sorter end_sorting
//
// Optional feature macro: PROJ_HASHER_SEED_LOAD_EN (run-time loadable seed).
// Without it the seed is the constant SEED.
//
// The pipeline slots use proj_pkg::hasher_stage_t, so SIGNATURE_LEN and
// INDICE_LEN must stay at their package values.
// -----------------------------------------------------------------------------
module proj_hasher
    import proj_pkg::*;
#(
    parameter int                       DATA_LEN      = HASHER_DATA_LEN,
    parameter int                       SIGNATURE_LEN = HASHER_SORTER_SIGNATURE,
    parameter int                       INDICE_LEN    = proj_pkg::INDICE_LEN,
    parameter logic [SIGNATURE_LEN-1:0] MULT          = HASHER_MULT,
    parameter logic [SIGNATURE_LEN-1:0] SEED          = HASHER_SEED
) (
    input  logic                     in_clk,
    input  logic                     in_rst_n,
    input  logic [DATA_LEN-1:0]      in_data,
    input  logic                     in_valid,
    input  logic                     in_last,
`ifdef PROJ_HASHER_SEED_LOAD_EN
    input  logic [SIGNATURE_LEN-1:0] in_seed,
    input  logic                     in_seed_load,
`endif
    output logic [SIGNATURE_LEN-1:0] out_signature,
    output logic [INDICE_LEN-1:0]    out_index,
    output logic                     out_valid,
    output logic                     out_end
);

    logic [SIGNATURE_LEN-1:0] data_ext;
    logic [SIGNATURE_LEN-1:0] seed;
    logic [SIGNATURE_LEN-1:0] mul_res;
    logic [SIGNATURE_LEN-1:0] mix_res;

    logic [INDICE_LEN-1:0]    cnt_q, cnt_d;
    hasher_stage_t            s1_q, s1_d;
    hasher_stage_t            s2_q, s2_d;
    hasher_stage_t            s3_q, s3_d;

    logic [SIGNATURE_LEN-1:0] sig_q, sig_d;
    logic [INDICE_LEN-1:0]    idx_q, idx_d;
    logic                     vld_q, vld_d;
    logic                     end_q, end_d;

    // Fit the input word to the signature width (zero-extend or truncate).
    if (DATA_LEN >= SIGNATURE_LEN) begin : g_trunc
        assign data_ext = in_data[SIGNATURE_LEN-1:0];
    end else begin : g_zext
        assign data_ext = {{(SIGNATURE_LEN-DATA_LEN){1'b0}}, in_data};
    end

`ifdef PROJ_HASHER_SEED_LOAD_EN
    logic [SIGNATURE_LEN-1:0] seed_q, seed_d;

    // An item accepted on a load edge sees seed_q before the update, i.e.
    // the old seed; in-flight items already carry their seeded value.
    always_comb begin
        seed_d = seed_q;
        if (in_seed_load) begin
            seed_d = in_seed;
        end
    end

    always_ff @(posedge in_clk) begin
        if (!in_rst_n) begin
            seed_q <= SEED;
        end else begin
            seed_q <= seed_d;
        end
    end

    assign seed = seed_q;
`else
    assign seed = SEED;
`endif

    proj_hash_mix #(
        .SIGNATURE_LEN (SIGNATURE_LEN),
        .MULT          (MULT)
    ) u_mix (
        .mul_a_i (s1_q.value),
        .mul_o   (mul_res),
        .mix_b_i (s2_q.value),
        .mix_o   (mix_res)
    );

    always_comb begin
        // Index counter: tag with the current count, restart after a last item.
        cnt_d = cnt_q;
        if (in_valid) begin
            cnt_d = in_last ? '0 : cnt_q + 1'b1;
        end

        // Stage 1 boundary: seeded word, index and framing captured on accept.
        s1_d.valid = in_valid;
        s1_d.last  = in_valid & in_last;
        s1_d.index = cnt_q;
        s1_d.value = data_ext ^ seed;

        // Stage 2 boundary: low half of the product.
        s2_d       = s1_q;
        s2_d.value = mul_res;

        // Stage 3 boundary: xorshift-folded, sentinel-clamped hash.
        s3_d       = s2_q;
        s3_d.value = mix_res;

        // Output boundary: empty slots present the sentinel and zero index.
        vld_d = s3_q.valid;
        end_d = s3_q.valid & s3_q.last;
        sig_d = s3_q.valid ? s3_q.value : HASHER_SENTINEL;
        idx_d = s3_q.valid ? s3_q.index : '0;
    end

    always_ff @(posedge in_clk) begin
        // Hash values and indices need no reset: the valid flags gate them.
        s1_q.value <= s1_d.value;
        s1_q.index <= s1_d.index;
        s2_q.value <= s2_d.value;
        s2_q.index <= s2_d.index;
        s3_q.value <= s3_d.value;
        s3_q.index <= s3_d.index;

        if (!in_rst_n) begin
            cnt_q      <= '0;
            s1_q.valid <= 1'b0;
            s1_q.last  <= 1'b0;
            s2_q.valid <= 1'b0;
            s2_q.last  <= 1'b0;
            s3_q.valid <= 1'b0;
            s3_q.last  <= 1'b0;
            vld_q      <= 1'b0;
            end_q      <= 1'b0;
            sig_q      <= HASHER_SENTINEL;
            idx_q      <= '0;
        end else begin
            cnt_q      <= cnt_d;
            s1_q.valid <= s1_d.valid;
            s1_q.last  <= s1_d.last;
            s2_q.valid <= s2_d.valid;
            s2_q.last  <= s2_d.last;
            s3_q.valid <= s3_d.valid;
            s3_q.last  <= s3_d.last;
            vld_q      <= vld_d;
            end_q      <= end_d;
            sig_q      <= sig_d;
            idx_q      <= idx_d;
        end
    end

    assign out_signature = sig_q;
    assign out_index     = idx_q;
    assign out_valid     = vld_q;
    assign out_end       = end_q;

endmodule : proj_hasher

// File: tb/tb_proj_hasher.sv
// -----------------------------------------------------------------------------
// tb_proj_hasher
// Directed bench for proj_hasher: a default instance and a MULT = 1 instance
// share one input stream. Expected signatures are hand-computed constants.
// Seed-load steps are compiled in when PROJ_HASHER_SEED_LOAD_EN is defined.
// -----------------------------------------------------------------------------
module tb_proj_hasher;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] data;
    logic        valid;
    logic        last;
    logic [31:0] seed;
    logic        seed_load;

    logic [31:0] sig,  sig1;
    logic [7:0]  idx,  idx1;
    logic        vld,  vld1;
    logic        endo, endo1;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    proj_hasher dut (
        .in_clk        (clk),
        .in_rst_n      (rst_n),
        .in_data       (data),
        .in_valid      (valid),
        .in_last       (last),
`ifdef PROJ_HASHER_SEED_LOAD_EN
        .in_seed       (seed),
        .in_seed_load  (seed_load),
`endif
        .out_signature (sig),
        .out_index     (idx),
        .out_valid     (vld),
        .out_end       (endo)
    );

    proj_hasher #(.MULT(32'h0000_0001)) dut_m1 (
        .in_clk        (clk),
        .in_rst_n      (rst_n),
        .in_data       (data),
        .in_valid      (valid),
        .in_last       (last),
`ifdef PROJ_HASHER_SEED_LOAD_EN
        .in_seed       (seed),
        .in_seed_load  (seed_load),
`endif
        .out_signature (sig1),
        .out_index     (idx1),
        .out_valid     (vld1),
        .out_end       (endo1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of input, step past the edge, settle before sampling.
    task automatic cyc(input logic [31:0] d, input logic v, input logic l);
        data  = d;
        valid = v;
        last  = l;
        @(posedge clk);
        #1;
    endtask

    // Hashes of data 0..9 with seed 0, then a single-item set with data 1.
    logic [31:0] exp_sig [0:10];
    initial begin
        exp_sig[0]  = 32'h0000_0000;
        exp_sig[1]  = 32'h9E37_E786;
        exp_sig[2]  = 32'h3C6E_CF0C;
        exp_sig[3]  = 32'hDAA6_B7B5;
        exp_sig[4]  = 32'h78DD_9E19;
        exp_sig[5]  = 32'h1715_7760;
        exp_sig[6]  = 32'hB54C_6F6A;
        exp_sig[7]  = 32'h5384_0053;
        exp_sig[8]  = 32'hF1BB_3C33;
        exp_sig[9]  = 32'h8FF3_C8CA;
        exp_sig[10] = 32'h9E37_E786;
    end

    initial begin
        rst_n     = 1'b0;
        data      = '0;
        valid     = 1'b0;
        last      = 1'b0;
        seed      = '0;
        seed_load = 1'b0;

        // Reset values.
        repeat (3) cyc(32'd0, 1'b0, 1'b0);
        chk("rst_sig",    sig,  32'hFFFF_FFFF);
        chk("rst_idx",    {24'd0, idx}, 32'd0);
        chk("rst_vld",    {31'd0, vld}, 32'd0);
        chk("rst_end",    {31'd0, endo}, 32'd0);
        chk("rst_m1_sig", sig1, 32'hFFFF_FFFF);

        // Idle after reset, with in_last alone (no in_valid) ignored.
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cyc(32'd0, 1'b0, (k == 1));
            chk("idle_sig", sig, 32'hFFFF_FFFF);
            chk("idle_vld", {31'd0, vld}, 32'd0);
            chk("idle_end", {31'd0, endo}, 32'd0);
        end

        // Single item with last: visible exactly three edges later.
        cyc(32'd1, 1'b1, 1'b1);
        for (int k = 1; k <= 4; k++) begin
            cyc(32'd0, 1'b0, 1'b0);
            if (k < 3) begin
                chk("lat_early_vld", {31'd0, vld}, 32'd0);
            end else if (k == 3) begin
                chk("one_sig", sig, 32'h9E37_E786);
                chk("one_idx", {24'd0, idx}, 32'd0);
                chk("one_vld", {31'd0, vld}, 32'd1);
                chk("one_end", {31'd0, endo}, 32'd1);
            end else begin
                chk("one_after_vld", {31'd0, vld}, 32'd0);
                chk("one_after_end", {31'd0, endo}, 32'd0);
                chk("one_after_sig", sig, 32'hFFFF_FFFF);
            end
        end

        // Set of ten (0..9, last on 9) followed back-to-back by a one-item set.
        for (int j = 0; j < 14; j++) begin
            if (j < 11) begin
                cyc((j < 10) ? 32'(j) : 32'd1, 1'b1, (j == 9) || (j == 10));
            end else begin
                cyc(32'd0, 1'b0, 1'b0);
            end
            if (j < 3) begin
                chk("seq_fill_vld", {31'd0, vld}, 32'd0);
            end else begin
                chk("seq_sig", sig, exp_sig[j-3]);
                chk("seq_idx", {24'd0, idx}, (j - 3 < 10) ? 32'(j - 3) : 32'd0);
                chk("seq_vld", {31'd0, vld}, 32'd1);
                chk("seq_end", {31'd0, endo}, ((j - 3) == 9 || (j - 3) == 10) ? 32'd1 : 32'd0);
            end
        end
        cyc(32'd0, 1'b0, 1'b0);
        chk("seq_drain_vld", {31'd0, vld}, 32'd0);

        // Index wrap: 257 items, the 257th wraps to index 0 and carries last.
        for (int j = 0; j < 260; j++) begin
            if (j < 257) begin
                cyc(32'd0, 1'b1, (j == 256));
            end else begin
                cyc(32'd0, 1'b0, 1'b0);
            end
            if (j >= 3) begin
                chk("wrap_idx", {24'd0, idx}, 32'((j - 3) % 256));
                chk("wrap_end", {31'd0, endo}, ((j - 3) == 256) ? 32'd1 : 32'd0);
            end
        end

        // Sentinel clamp on the MULT = 1 instance; default instance alongside.
        cyc(32'hFFFF_0000, 1'b1, 1'b1);
        repeat (3) cyc(32'd0, 1'b0, 1'b0);
        chk("clamp_m1_sig", sig1, 32'hFFFF_FFFE);
        chk("clamp_m1_vld", {31'd0, vld1}, 32'd1);
        chk("clamp_m1_idx", {24'd0, idx1}, 32'd0);
        chk("clamp_m1_end", {31'd0, endo1}, 32'd1);
        chk("clamp_def_sig", sig, 32'h864F_864F);

        // Reset one cycle after a last item: nothing emerges for it.
        cyc(32'd5, 1'b1, 1'b0);
        cyc(32'd7, 1'b1, 1'b1);
        rst_n = 1'b0;
        cyc(32'd0, 1'b0, 1'b0);
        chk("midrst_sig", sig, 32'hFFFF_FFFF);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cyc(32'd0, 1'b0, 1'b0);
            chk("midrst_vld", {31'd0, vld}, 32'd0);
            chk("midrst_end", {31'd0, endo}, 32'd0);
        end
        cyc(32'd3, 1'b1, 1'b0);
        repeat (3) cyc(32'd0, 1'b0, 1'b0);
        chk("post_rst_idx", {24'd0, idx}, 32'd0);
        chk("post_rst_sig", sig, 32'hDAA6_B7B5);
        chk("post_rst_vld", {31'd0, vld}, 32'd1);
        chk("post_rst_end", {31'd0, endo}, 32'd0);

`ifdef PROJ_HASHER_SEED_LOAD_EN
        // Load seed = 1 on the same edge as data = 1: old seed applies to it.
        seed      = 32'd1;
        seed_load = 1'b1;
        cyc(32'd1, 1'b1, 1'b0);
        seed_load = 1'b0;
        cyc(32'd1, 1'b1, 1'b1);
        cyc(32'd0, 1'b0, 1'b0);
        cyc(32'd0, 1'b0, 1'b0);
        chk("seed_old_sig", sig, 32'h9E37_E786);
        chk("seed_old_vld", {31'd0, vld}, 32'd1);
        cyc(32'd0, 1'b0, 1'b0);
        chk("seed_new_sig", sig, 32'h0000_0000);
        chk("seed_new_end", {31'd0, endo}, 32'd1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_proj_hasher
